// File: rtl/vga_scan_engine.sv
// 640x480 scan generator with 5x-upscaled 1-bit framebuffer fetch.
// Stage 0 counters drive fb_addr; the BRAM read is stage 1; colour and syncs are registered in stage 2.
module vga_scan_engine #(
  parameter int         H_VIS    = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_VIS    = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter logic       SYNC_POL = 1'b0,
  parameter int         SCALE    = 5,
  parameter logic [7:0] FG_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic        clk2,
  input  logic        rst,
  output logic [13:0] fb_addr,
  input  logic        fb_data,
  output logic [7:0]  color,
  output logic        h_sync,
  output logic        v_sync,
  output logic        blank,
  output logic        frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
  localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
  localparam logic [9:0] HS_BEG     = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG     = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [2:0] SUB_LAST   = 3'(SCALE - 1);

  logic [9:0] hcnt, vcnt, hcnt_n, vcnt_n;
  logic [2:0] hsub, vsub, hsub_n, vsub_n;
  logic [6:0] col, row, col_n, row_n;
  logic       h_wrap;
  logic       vis0, hs0, vs0, first0;
  logic       vis1, hs1, vs1, first1;

  // Cell counters follow the pixel counters so col/row are always hcnt/SCALE, vcnt/SCALE.
  always_comb begin
    h_wrap = (hcnt == H_LAST);
    hcnt_n = h_wrap ? 10'd0 : hcnt + 10'd1;
    vcnt_n = vcnt;
    if (h_wrap)
      vcnt_n = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;

    hsub_n = hsub + 3'd1;
    col_n  = col;
    if (hcnt >= H_VIS_LAST) begin
      hsub_n = 3'd0;
      col_n  = 7'd0;
    end else if (hsub == SUB_LAST) begin
      hsub_n = 3'd0;
      col_n  = col + 7'd1;
    end

    vsub_n = vsub;
    row_n  = row;
    if (h_wrap) begin
      if (vcnt >= V_VIS_LAST) begin
        vsub_n = 3'd0;
        row_n  = 7'd0;
      end else if (vsub == SUB_LAST) begin
        vsub_n = 3'd0;
        row_n  = row + 7'd1;
      end else begin
        vsub_n = vsub + 3'd1;
      end
    end
  end

  always_comb begin
    vis0   = (hcnt < H_VIS_W) && (vcnt < V_VIS_W);
    hs0    = (hcnt >= HS_BEG) && (hcnt <= HS_END);
    vs0    = (vcnt >= VS_BEG) && (vcnt <= VS_END);
    first0 = (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  // row/col registers are the address itself, so fb_addr tracks stage 0 with no extra flop.
  assign fb_addr = {row, col};

  always_ff @(posedge clk2) begin
    if (!rst) begin
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      hsub        <= 3'd0;
      vsub        <= 3'd0;
      col         <= 7'd0;
      row         <= 7'd0;
      vis1        <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      first1      <= 1'b0;
      color       <= BG_COLOR;
      blank       <= 1'b1;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hcnt        <= hcnt_n;
      vcnt        <= vcnt_n;
      hsub        <= hsub_n;
      vsub        <= vsub_n;
      col         <= col_n;
      row         <= row_n;
      vis1        <= vis0;
      hs1         <= hs0;
      vs1         <= vs0;
      first1      <= first0;
      color       <= (vis1 && fb_data) ? FG_COLOR : BG_COLOR;
      blank       <= ~vis1;
      h_sync      <= hs1 ? SYNC_POL : ~SYNC_POL;
      v_sync      <= vs1 ? SYNC_POL : ~SYNC_POL;
      frame_start <= first1;
    end
  end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Checks vga_scan_engine cycle by cycle against an arithmetic screen model on a short-frame geometry.
// Horizontal timing is full size; vertical is shortened so whole frames fit in a brief run.
module tb_vga_scan_engine;

  localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_VIS = 10, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int SCALE = 5;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk2 = 1'b0;
  logic        rst = 1'b0;
  logic        fb_data = 1'b0;
  logic [13:0] fb_addr;
  logic [7:0]  color;
  logic        h_sync, v_sync, blank, frame_start;

  int n_checks = 0;
  int n_fail = 0;
  int k = 0;
  bit mem [16384];
  bit force_one = 1'b0;
  int hs_low, vs_low, vis_cnt, fs_cnt, first_hs;
  int exp_line0 [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2};

  vga_scan_engine #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk2(clk2),
    .rst(rst),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .color(color),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .blank(blank),
    .frame_start(frame_start)
  );

  always #20 clk2 = ~clk2;

  // Synchronous-read BRAM: data appears one clock after the address.
  always @(posedge clk2) fb_data <= force_one ? 1'b1 : mem[fb_addr];

  function automatic int addr_of(int p);
    int h, v, r, c;
    h = p % H_TOT;
    v = (p / H_TOT) % V_TOT;
    r = (v < V_VIS) ? v / SCALE : 0;
    c = (h < H_VIS) ? h / SCALE : 0;
    return r * 128 + c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_color", 32'(color), 0);
    check("rst_blank", 32'(blank), 1);
    check("rst_h_sync", 32'(h_sync), 1);
    check("rst_v_sync", 32'(v_sync), 1);
    check("rst_frame_start", 32'(frame_start), 0);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk2);
    rst = 1'b0;
    repeat (cycles) @(posedge clk2);
    @(negedge clk2);
    k = 0;
    check_reset_values();
    rst = 1'b1;
  endtask

  // Advance one clock and compare every output with the screen position it should show.
  task automatic step_check();
    int p, h, v;
    bit vis, hs, vs, first, data;
    @(posedge clk2);
    k++;
    @(negedge clk2);
    check("fb_addr", 32'(fb_addr), 32'(addr_of(k)));
    if (k < 2) begin
      check("early_color", 32'(color), 0);
      check("early_blank", 32'(blank), 1);
      check("early_h_sync", 32'(h_sync), 1);
      check("early_v_sync", 32'(v_sync), 1);
      check("early_frame_start", 32'(frame_start), 0);
    end else begin
      p = k - 2;
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      vis = (h < H_VIS) && (v < V_VIS);
      hs = (h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC);
      vs = (v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC);
      first = (p % FRAME) == 0;
      data = force_one ? 1'b1 : mem[addr_of(p)];
      check("color", 32'(color), (vis && data) ? 32'hFF : 32'h00);
      check("blank", 32'(blank), 32'(!vis));
      check("h_sync", 32'(h_sync), 32'(!hs));
      check("v_sync", 32'(v_sync), 32'(!vs));
      check("frame_start", 32'(frame_start), 32'(first));
      if (!h_sync) hs_low++;
      if (!v_sync) vs_low++;
      if (!blank) vis_cnt++;
      if (frame_start) fs_cnt++;
      if (!h_sync && first_hs < 0) first_hs = k;
    end
  endtask

  initial begin
    $display("[TB] start");
    for (int i = 0; i < 16384; i++) mem[i] = 1'($urandom_range(1, 0));

    // Two free-running frames over random framebuffer contents.
    hs_low = 0; vs_low = 0; vis_cnt = 0; fs_cnt = 0; first_hs = -1;
    apply_reset(3);
    for (int i = 0; i < 2 * FRAME + 1; i++) begin
      step_check();
      if (k <= 10) check("addr_line0", 32'(fb_addr), 32'(exp_line0[k]));
      if (k == 5 * H_TOT) check("addr_line5", 32'(fb_addr), 128);
      if (k == (V_VIS - 1) * H_TOT + H_VIS - 1) check("addr_last_pixel", 32'(fb_addr), 255);
    end
    check("first_hsync_low", 32'(first_hs), 658);
    check("hsync_low_cycles", 32'(hs_low), 32'(2 * V_TOT * H_SYNC));
    check("vsync_low_cycles", 32'(vs_low), 32'(2 * V_SYNC * H_TOT));
    check("visible_cycles", 32'(vis_cnt), 32'(2 * V_VIS * H_VIS));
    check("frame_start_count", 32'(fs_cnt), 2);

    // Data tied high: colour must still follow blank; then abort the frame mid-screen.
    force_one = 1'b1;
    apply_reset(3);
    while (k < 5 * H_TOT + 300) step_check();
    apply_reset(1);
    fs_cnt = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      step_check();
      if (k == 2) check("restart_frame_start", 32'(frame_start), 1);
    end
    check("restart_frame_count", 32'(fs_cnt), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
